graph_mem_loader: RTL and testbench
===================================

Name: graph_mem_loader

Overview:
- Writer-side front end for the DFS shortest-path engine: takes edges over a valid/ready stream and writes a symmetric adjacency matrix into the graph memory that the engine's datapath reads.
- Clears the matrix after reset, mirrors each accepted edge, then pulses the engine start.
- Blocks new loads until the engine reports done.

Parameters:
- NODES, 6, number of graph nodes; matrix is NODES x NODES words.
- NODE_W, 3, node index width; clog2(NODES) or wider.
- WEIGHT_W, 15, edge weight width; matches the MIN_WEIGHT width.
- ADDR_W, 18, memory address width.
- DATA_W, 18, memory word width; must be >= WEIGHT_W.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, edge word present.
- in_ready, output, 1, loader accepts the edge this cycle.
- in_src, input, NODE_W, edge source node.
- in_dst, input, NODE_W, edge destination node.
- in_weight, input, WEIGHT_W, edge weight; 0 is illegal.
- in_last, input, 1, final edge of the graph.
- mem_we, output, 1, memory write strobe.
- mem_addr, output, ADDR_W, write address = row*NODES + col.
- mem_wdata, output, DATA_W, zero-extended weight; 0 = no edge.
- search_start, output, 1, one-cycle start pulse to the engine.
- search_done, input, 1, engine done level/pulse.
- busy, output, 1, high in every state except ACCEPT.
- drop_cnt, output, 8, saturating count of rejected edges since reset.

Behaviour:
- Reset: state=CLEAR, clear counter=0, mem_we=0, mem_addr=0, mem_wdata=0, in_ready=0, search_start=0, busy=1, drop_cnt=0. Reset mid-operation aborts the current state and restarts the clear sequence; no start pulse is issued.
- All outputs are registered; in_ready is a state decode (ACCEPT only).
- CLEAR:
  - Writes 0 to addresses 0..NODES*NODES-1, one per cycle; mem_we=1 each cycle.
  - Takes exactly NODES*NODES cycles (36 by default), then goes to ACCEPT.
- ACCEPT:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Legal edge: in_src<NODES, in_dst<NODES, in_src!=in_dst, in_weight!=0.
  - On a legal handshake: next cycle mem_we=1, mem_addr=src*NODES+dst, mem_wdata=weight; latch src/dst/weight/last; go to MIRROR.
  - On an illegal handshake: no write; drop_cnt+=1, saturating at 255. If in_last=1, go to START; otherwise stay in ACCEPT.
  - No handshake: mem_we=0.
- MIRROR:
  - mem_we=1, mem_addr=dst*NODES+src, same weight. in_ready=0.
  - Next state is START if the latched last=1, otherwise ACCEPT.
  - Each legal edge therefore costs 2 cycles; maximum throughput is 1 edge per 2 cycles.
- Duplicate edges: a later write overwrites the earlier one (last-writer-wins); no detection.
- START: search_start=1 for exactly one cycle, mem_we=0; go to WAIT.
- WAIT:
  - Hold until search_done=1 is sampled.
  - search_done already high on the first WAIT cycle is honoured; the engine holds done from a previous run, so the team's integration gates done by start.
  - Then go to CLEAR, i.e. a fresh load follows every search.
- search_done outside WAIT is ignored.
- in_valid outside ACCEPT: not accepted. The upstream holds data stable until in_ready is seen.
- Address arithmetic is done in ADDR_W bits; the maximum address NODES*NODES-1 must fit.

Test Plan:
- Reset release: 36 cycles of mem_we=1 with addr 0..35 and wdata 0; in_ready first goes 1 on cycle 37; busy=1 throughout the clear.
- Edge (src=1, dst=4, w=100, last=0): writes addr 10 then addr 25, both wdata=100, on consecutive cycles; in_ready drops for the mirror cycle only.
- Last edge (0, 5, 7, last=1): writes addr 5 and addr 30; search_start pulses exactly one cycle after the mirror write; busy stays 1; in_ready stays 0 until search_done.
- Illegal edges (src=2,dst=2), (src=6,dst=0), (src=1,dst=3,w=0): no mem_we; drop_cnt=3. The same with last=1 on the third: start pulse follows directly with no write.
- search_done asserted for 1 cycle during WAIT: a full 36-cycle clear restarts, then ACCEPT. search_done pulsed during ACCEPT: no state change.
- rst asserted mid-MIRROR and mid-WAIT: next cycle is clear addr 0, no search_start, drop_cnt=0.

Source files
------------

// File: rtl/graph_mem_loader.sv
// graph_mem_loader
//   Writer-side front end for the DFS shortest-path engine. Clears the
//   NODES x NODES adjacency matrix, then accepts edges over a valid/ready
//   stream and writes each one twice (row/col and col/row) so the matrix stays
//   symmetric. After the final edge it pulses search_start and holds off new
//   loads until the engine reports search_done. A fresh clear follows every
//   search.
//
// Ports
//   clk, rst          rising-edge clock, synchronous active-high reset
//   in_valid/in_ready edge stream handshake (in_ready high only in ACCEPT)
//   in_src, in_dst    edge endpoints
//   in_weight         edge weight, 0 is illegal
//   in_last           final edge of the graph
//   mem_we/addr/wdata graph memory write port, addr = row*NODES + col
//   search_start      one-cycle start pulse to the engine
//   search_done       engine done, honoured only while waiting
//   busy              high in every state except ACCEPT
//   drop_cnt          saturating count of rejected edges since reset
//
// Timing model: in_ready and busy track the current state. The memory
// strobe/address/data and search_start carry the action taken by the state of
// the previous cycle, so a handshake in cycle t shows its forward write in t+1
// and its mirror write in t+2.

module graph_mem_loader #(
  parameter int unsigned NODES    = 6,
  parameter int unsigned NODE_W   = 3,
  parameter int unsigned WEIGHT_W = 15,
  parameter int unsigned ADDR_W   = 18,
  parameter int unsigned DATA_W   = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [NODE_W-1:0]   in_src,
  input  logic [NODE_W-1:0]   in_dst,
  input  logic [WEIGHT_W-1:0] in_weight,
  input  logic                in_last,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                search_start,
  input  logic                search_done,
  output logic                busy,
  output logic [7:0]          drop_cnt
);

  localparam int unsigned CELLS = NODES * NODES;
  localparam int unsigned CLR_W = $clog2(CELLS + 1);

  typedef enum logic [2:0] {
    ST_CLEAR  = 3'd0,
    ST_ACCEPT = 3'd1,
    ST_MIRROR = 3'd2,
    ST_START  = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  state_t              state;
  logic [CLR_W-1:0]    clr_cnt;
  logic [NODE_W-1:0]   src_q;
  logic [NODE_W-1:0]   dst_q;
  logic [WEIGHT_W-1:0] weight_q;
  logic                last_q;

  logic                hs_c;
  logic                edge_legal_c;
  logic                clr_done_c;
  logic [ADDR_W-1:0]   fwd_addr_c;
  logic [ADDR_W-1:0]   mir_addr_c;

  // Row-major matrix address, computed entirely in ADDR_W bits.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [NODE_W-1:0] row,
                                                   input logic [NODE_W-1:0] col);
    return ADDR_W'(row) * ADDR_W'(NODES) + ADDR_W'(col);
  endfunction

  // Handshake, edge legality and both write addresses.
  always_comb begin
    hs_c         = in_valid & in_ready;
    edge_legal_c = (32'(in_src) < NODES) && (32'(in_dst) < NODES) &&
                   (in_src != in_dst) && (in_weight != '0);
    clr_done_c   = (clr_cnt == CLR_W'(CELLS));
    fwd_addr_c   = cell_addr(in_src, in_dst);
    mir_addr_c   = cell_addr(dst_q, src_q);
  end

  // Loader state machine with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_CLEAR;
      clr_cnt      <= '0;
      src_q        <= '0;
      dst_q        <= '0;
      weight_q     <= '0;
      last_q       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      in_ready     <= 1'b0;
      search_start <= 1'b0;
      busy         <= 1'b1;
      drop_cnt     <= 8'd0;
    end else begin
      mem_we       <= 1'b0;
      search_start <= 1'b0;

      case (state)
        // One zero word per cycle; the cycle after the last word opens ACCEPT.
        ST_CLEAR: begin
          if (clr_done_c) begin
            state    <= ST_ACCEPT;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end else begin
            mem_we    <= 1'b1;
            mem_addr  <= ADDR_W'(clr_cnt);
            mem_wdata <= '0;
            clr_cnt   <= CLR_W'(clr_cnt + 1'b1);
          end
        end

        ST_ACCEPT: begin
          if (hs_c) begin
            if (edge_legal_c) begin
              mem_we    <= 1'b1;
              mem_addr  <= fwd_addr_c;
              mem_wdata <= DATA_W'(in_weight);
              src_q     <= in_src;
              dst_q     <= in_dst;
              weight_q  <= in_weight;
              last_q    <= in_last;
              state     <= ST_MIRROR;
              in_ready  <= 1'b0;
              busy      <= 1'b1;
            end else begin
              if (drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
              end
              // A rejected final edge still ends the graph.
              if (in_last) begin
                state    <= ST_START;
                in_ready <= 1'b0;
                busy     <= 1'b1;
              end
            end
          end
        end

        // Transposed copy of the edge just written.
        ST_MIRROR: begin
          mem_we    <= 1'b1;
          mem_addr  <= mir_addr_c;
          mem_wdata <= DATA_W'(weight_q);
          if (last_q) begin
            state    <= ST_START;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end else begin
            state    <= ST_ACCEPT;
            in_ready <= 1'b1;
            busy     <= 1'b0;
          end
        end

        ST_START: begin
          search_start <= 1'b1;
          state        <= ST_WAIT;
        end

        // Done may already be high on entry; it is taken on the first sample.
        ST_WAIT: begin
          if (search_done) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
          end
        end

        default: begin
          state    <= ST_CLEAR;
          clr_cnt  <= '0;
          in_ready <= 1'b0;
          busy     <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_graph_mem_loader.sv
// Directed bench for graph_mem_loader: clear sequence, forward/mirror writes,
// rejected edges, start/done handshake, resets mid-operation, drop saturation.
module tb_graph_mem_loader;

  localparam int unsigned NODES    = 6;
  localparam int unsigned NODE_W   = 3;
  localparam int unsigned WEIGHT_W = 15;
  localparam int unsigned ADDR_W   = 18;
  localparam int unsigned DATA_W   = 18;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [NODE_W-1:0]   in_src;
  logic [NODE_W-1:0]   in_dst;
  logic [WEIGHT_W-1:0] in_weight;
  logic                in_last;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                search_start;
  logic                search_done;
  logic                busy;
  logic [7:0]          drop_cnt;

  int checks   = 0;
  int failures = 0;

  graph_mem_loader #(
    .NODES   (NODES),
    .NODE_W  (NODE_W),
    .WEIGHT_W(WEIGHT_W),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_src      (in_src),
    .in_dst      (in_dst),
    .in_weight   (in_weight),
    .in_last     (in_last),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .search_start(search_start),
    .search_done (search_done),
    .busy        (busy),
    .drop_cnt    (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Snapshot layout: we, ready, start, busy, drop[7:0], addr[17:0], wdata[17:0]
  logic [47:0] obs;
  assign obs = {mem_we, in_ready, search_start, busy, drop_cnt, mem_addr, mem_wdata};

  function automatic logic [47:0] pack(input logic we, input logic rdy,
                                       input logic st, input logic bsy,
                                       input int drp, input int addr, input int wd);
    return {we, rdy, st, bsy, 8'(drp), 18'(addr), 18'(wd)};
  endfunction

  // Address/data are compared only when a write is expected, unless full=1.
  task automatic chk(input string tag, input logic [47:0] exp, input bit full = 1'b0);
    logic [47:0] m;
    m = (full || exp[47]) ? '1 : {12'hFFF, 36'h0};
    checks++;
    assert ((obs & m) === (exp & m)) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs & m, exp & m);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int s, input int d, input int w, input bit l);
    in_valid  = 1'b1;
    in_src    = NODE_W'(s);
    in_dst    = NODE_W'(d);
    in_weight = WEIGHT_W'(w);
    in_last   = l;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // 36 zero writes to addresses 0..35, then ACCEPT opens on the next cycle.
  task automatic run_clear(input int drp);
    for (int k = 0; k < 36; k++) begin
      tick();
      chk($sformatf("clear_%0d", k), pack(1, 0, 0, 1, drp, k, 0));
    end
    tick();
    chk("clear_exit", pack(0, 1, 0, 0, drp, 0, 0));
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_src = '0; in_dst = '0;
    in_weight = '0; in_last = 1'b0; search_done = 1'b0;
    tick();
    tick();
    chk("reset", pack(0, 0, 0, 1, 0, 0, 0), 1'b1);
    rst = 1'b0;
    run_clear(0);

    // Edge 1->4 w=100: addr 10 then addr 25.
    send(1, 4, 100, 1'b0);
    tick(); chk("edge_fwd", pack(1, 0, 0, 1, 0, 10, 100));
    idle();
    tick(); chk("edge_mirror", pack(1, 1, 0, 0, 0, 25, 100));
    tick(); chk("accept_idle", pack(0, 1, 0, 0, 0, 0, 0));

    // Rejected edges: self loop, out-of-range src, zero weight.
    send(2, 2, 5, 1'b0);
    tick(); chk("drop_self", pack(0, 1, 0, 0, 1, 0, 0));
    send(6, 0, 5, 1'b0);
    tick(); chk("drop_range", pack(0, 1, 0, 0, 2, 0, 0));
    send(1, 3, 0, 1'b0);
    tick(); chk("drop_zero_w", pack(0, 1, 0, 0, 3, 0, 0));
    idle();

    // Done outside WAIT is ignored.
    search_done = 1'b1;
    tick(); chk("done_in_accept", pack(0, 1, 0, 0, 3, 0, 0));
    search_done = 1'b0;

    // Final edge 0->5 w=7: addr 5, addr 30, then start pulse.
    send(0, 5, 7, 1'b1);
    tick(); chk("last_fwd", pack(1, 0, 0, 1, 3, 5, 7));
    idle();
    tick(); chk("last_mirror", pack(1, 0, 0, 1, 3, 30, 7));
    tick(); chk("start_pulse", pack(0, 0, 1, 1, 3, 0, 0));
    tick(); chk("wait_0", pack(0, 0, 0, 1, 3, 0, 0));

    // Upstream offers an edge while waiting; it must be held off.
    send(2, 3, 9, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk($sformatf("wait_hold_%0d", i), pack(0, 0, 0, 1, 3, 0, 0));
    end
    search_done = 1'b1;
    tick(); chk("done_taken", pack(0, 0, 0, 1, 3, 0, 0));
    search_done = 1'b0;
    run_clear(3);
    // The held edge 2->3 w=9 is taken once ACCEPT opens.
    tick(); chk("held_fwd", pack(1, 0, 0, 1, 3, 15, 9));
    idle();
    tick(); chk("held_mirror", pack(1, 1, 0, 0, 3, 20, 9));

    // Reset during MIRROR: no mirror write, clear restarts at addr 0.
    send(3, 1, 50, 1'b0);
    tick(); chk("pre_rst_fwd", pack(1, 0, 0, 1, 3, 19, 50));
    idle();
    rst = 1'b1;
    tick(); chk("rst_mirror", pack(0, 0, 0, 1, 0, 0, 0), 1'b1);
    rst = 1'b0;
    run_clear(0);

    // Rejected final edge: start follows directly with no write.
    send(2, 2, 5, 1'b0);
    tick(); chk("drop2_self", pack(0, 1, 0, 0, 1, 0, 0));
    send(6, 0, 5, 1'b0);
    tick(); chk("drop2_range", pack(0, 1, 0, 0, 2, 0, 0));
    send(1, 3, 0, 1'b1);
    tick(); chk("drop2_last", pack(0, 0, 0, 1, 3, 0, 0));
    idle();
    tick(); chk("drop2_start", pack(0, 0, 1, 1, 3, 0, 0));
    tick(); chk("drop2_wait", pack(0, 0, 0, 1, 3, 0, 0));

    // Reset during WAIT.
    rst = 1'b1;
    tick(); chk("rst_wait", pack(0, 0, 0, 1, 0, 0, 0), 1'b1);
    rst = 1'b0;
    run_clear(0);

    // Max weight, highest mirrored cell below the diagonal corner.
    send(4, 5, 32767, 1'b0);
    tick(); chk("maxw_fwd", pack(1, 0, 0, 1, 0, 29, 32767));
    idle();
    tick(); chk("maxw_mirror", pack(1, 1, 0, 0, 0, 34, 32767));

    // Drop counter saturates at 255.
    send(0, 0, 1, 1'b0);
    for (int i = 0; i < 254; i++) tick();
    chk("drop_254", pack(0, 1, 0, 0, 254, 0, 0));
    tick(); chk("drop_255", pack(0, 1, 0, 0, 255, 0, 0));
    for (int i = 0; i < 5; i++) tick();
    chk("drop_sat", pack(0, 1, 0, 0, 255, 0, 0));
    idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
